// File: rtl/hpi_bus_controller.sv
// Two-client HPI bus master: round-robin arbitration onto one strobed bus with
// fixed setup/strobe/hold timing, preceded by a chip-reset phase.
module hpi_bus_controller #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RST_CYC    = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs,
  output logic        otg_hpi_r,
  output logic        otg_hpi_w,
  output logic        otg_hpi_reset,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in,
  output logic        busy
);

  typedef enum logic [2:0] {CHIPRST, IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
  typedef struct packed {
    logic        id;
    logic        write;
    logic [1:0]  addr;
    logic [15:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  req_t              lat_q, lat_d, req_in;
  logic              last_q, last_d;
  logic [15:0]       samp_q, samp_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0][15:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        addr_q, addr_d;
  logic              cs_q, cs_d, r_q, r_d, w_q, w_d, oe_q, oe_d, chip_rst_q, chip_rst_d;
  logic [15:0]       dout_q, dout_d;
  logic              grant, accept, done, xfer, strobe;

  // On a tie the client not served last wins; otherwise the lone requester.
  assign grant      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = (state_q == IDLE) & ~grant;
  assign req1_ready = (state_q == IDLE) & grant;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign req_in     = grant ? {1'b1, req1_write, req1_addr, req1_wdata}
                            : {1'b0, req0_write, req0_addr, req0_wdata};
  assign done       = (cnt_q == 8'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    last_d      = last_q;
    samp_d      = samp_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      CHIPRST: if (done) state_d = IDLE; else cnt_d = cnt_q - 8'd1;
      IDLE: if (accept) begin
        lat_d   = req_in;
        last_d  = req_in.id;
        state_d = SETUP;
        cnt_d   = 8'(SETUP_CYC);
      end
      SETUP: if (done) begin
        state_d = STROBE;
        cnt_d   = 8'(STROBE_CYC);
      end else cnt_d = cnt_q - 8'd1;
      STROBE: if (done) begin
        state_d = HOLD;
        cnt_d   = 8'(HOLD_CYC);
        if (!lat_q.write) samp_d = otg_hpi_data_in;
      end else cnt_d = cnt_q - 8'd1;
      HOLD: if (done) begin
        state_d = RECOVER;
        cnt_d   = 8'd1;
        rsp_valid_d[lat_q.id] = 1'b1;
        if (!lat_q.write) rsp_rdata_d[lat_q.id] = samp_q;
      end else cnt_d = cnt_q - 8'd1;
      RECOVER: state_d = IDLE;
      default: begin
        state_d = CHIPRST;
        cnt_d   = 8'(RST_CYC);
      end
    endcase

    // Bus pins are registered, so they are decoded from the next state.
    xfer       = (state_d == SETUP) | (state_d == STROBE) | (state_d == HOLD);
    strobe     = (state_d == STROBE);
    addr_d     = xfer ? lat_d.addr : 2'b00;
    cs_d       = ~xfer;
    r_d        = ~(strobe & ~lat_d.write);
    w_d        = ~(strobe & lat_d.write);
    oe_d       = xfer & lat_d.write;
    dout_d     = oe_d ? lat_d.wdata : 16'h0;
    chip_rst_d = (state_d != CHIPRST);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= CHIPRST;
      cnt_q       <= 8'(RST_CYC);
      lat_q       <= '0;
      last_q      <= 1'b1;
      samp_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b1;
      r_q         <= 1'b1;
      w_q         <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      chip_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      last_q      <= last_d;
      samp_q      <= samp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      r_q         <= r_d;
      w_q         <= w_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      chip_rst_q  <= chip_rst_d;
    end
  end

  assign rsp0_valid       = rsp_valid_q[0];
  assign rsp1_valid       = rsp_valid_q[1];
  assign rsp0_rdata       = rsp_rdata_q[0];
  assign rsp1_rdata       = rsp_rdata_q[1];
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_cs       = cs_q;
  assign otg_hpi_r        = r_q;
  assign otg_hpi_w        = w_q;
  assign otg_hpi_reset    = chip_rst_q;
  assign otg_hpi_data_out = dout_q;
  assign otg_hpi_data_oe  = oe_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_hpi_bus_controller.sv
// Bench for hpi_bus_controller: transaction-level model of two clients and the
// bus timing, checked cycle by cycle under random and directed traffic.
module tb_hpi_bus_controller;
  localparam int S = 1, T = 4, H = 1, LAT = S + T + H + 1, RSTC = 16;

  logic        clk_clk = 1'b0, reset_reset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [1:0]  req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_wdata = '0, req1_wdata = '0, otg_hpi_data_in = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata, otg_hpi_data_out;
  logic [1:0]  otg_hpi_address;
  logic        otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset, otg_hpi_data_oe, busy;

  hpi_bus_controller #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RST_CYC(RSTC)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .otg_hpi_address(otg_hpi_address), .otg_hpi_cs(otg_hpi_cs), .otg_hpi_r(otg_hpi_r),
    .otg_hpi_w(otg_hpi_w), .otg_hpi_reset(otg_hpi_reset), .otg_hpi_data_out(otg_hpi_data_out),
    .otg_hpi_data_oe(otg_hpi_data_oe), .otg_hpi_data_in(otg_hpi_data_in), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Model: pending requests per client, one in-flight transfer at offset k.
  bit          pend[2], pw[2];
  logic [1:0]  pa[2];
  logic [15:0] pd[2];
  bit          act, a_id, a_w, last, use_fixed;
  int          k;
  logic [1:0]  a_addr;
  logic [15:0] a_wd, a_rd, fixed_rd;
  logic [15:0] exp_rd[2];
  int          g_id[$], g_cyc[$];

  task automatic model_reset();
    pend[0] = 0; pend[1] = 0; act = 0; k = 0; last = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    g_id.delete(); g_cyc.delete();
  endtask

  task automatic new_req(input int w);
    pend[w] = 1; pw[w] = 1'($urandom); pa[w] = 2'($urandom); pd[w] = 16'($urandom);
  endtask

  // Non-pending clients wiggle their request fields with valid low.
  task automatic drive_clients();
    req0_valid = pend[0];
    req0_write = pend[0] ? pw[0] : 1'($urandom);
    req0_addr  = pend[0] ? pa[0] : 2'($urandom);
    req0_wdata = pend[0] ? pd[0] : 16'($urandom);
    req1_valid = pend[1];
    req1_write = pend[1] ? pw[1] : 1'($urandom);
    req1_addr  = pend[1] ? pa[1] : 2'($urandom);
    req1_wdata = pend[1] ? pd[1] : 16'($urandom);
  endtask

  task automatic cycle();
    bit          xfer, rs, ws, egnt;
    logic [21:0] eb, ob;
    logic [1:0]  ev, er;
    @(negedge clk_clk);
    if (act) begin k++; if (k > LAT) act = 0; end
    if (act && k == LAT && !a_w) exp_rd[a_id] = a_rd;
    xfer = act && k >= 1 && k <= S + T + H;
    rs   = act && !a_w && k > S && k <= S + T;
    ws   = act && a_w && k > S && k <= S + T;
    eb = {!xfer, !rs, !ws, xfer ? a_addr : 2'b00, xfer && a_w, (xfer && a_w) ? a_wd : 16'h0};
    ob = {otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_address, otg_hpi_data_oe, otg_hpi_data_out};
    nvec++; if (ob !== eb) begin nerr++; $display("FAIL bus k=%0d got %h want %h", k, ob, eb); end
    ev = 2'b00; if (act && k == LAT) ev[a_id] = 1'b1;
    nvec++; if ({rsp1_valid, rsp0_valid} !== ev) begin nerr++; $display("FAIL rsp_valid k=%0d got %b want %b", k, {rsp1_valid, rsp0_valid}, ev); end
    nvec++; if (rsp0_rdata !== exp_rd[0]) begin nerr++; $display("FAIL rsp0_rdata got %h want %h", rsp0_rdata, exp_rd[0]); end
    nvec++; if (rsp1_rdata !== exp_rd[1]) begin nerr++; $display("FAIL rsp1_rdata got %h want %h", rsp1_rdata, exp_rd[1]); end
    nvec++; if ({busy, otg_hpi_reset} !== {act, 1'b1}) begin nerr++; $display("FAIL busy/reset got %b want %b", {busy, otg_hpi_reset}, {act, 1'b1}); end
    drive_clients();
    otg_hpi_data_in = (act && !a_w && k == S + T) ? a_rd : 16'($urandom);
    #1;
    egnt = (pend[0] && pend[1]) ? !last : pend[1];
    if (act || pend[0] || pend[1]) begin
      er = act ? 2'b00 : (egnt ? 2'b10 : 2'b01);
      nvec++; if ({req1_ready, req0_ready} !== er) begin nerr++; $display("FAIL ready got %b want %b", {req1_ready, req0_ready}, er); end
    end
    if (req0_valid && req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
    if (!act && (pend[0] || pend[1])) begin
      a_id = egnt; a_w = pw[egnt]; a_addr = pa[egnt]; a_wd = pd[egnt];
      a_rd = use_fixed ? fixed_rd : 16'($urandom);
      act = 1; k = 0; last = egnt; pend[egnt] = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (act || pend[0] || pend[1]); i++) cycle();
    nvec++; if (act || pend[0] || pend[1]) begin nerr++; $display("FAIL drain got busy want idle"); end
  endtask

  task automatic test_reset();
    int lows; bit done;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk_clk); #2; reset_reset_n = 0; #1;
    nvec++; if ({otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_address, otg_hpi_data_oe, otg_hpi_data_out} !== {3'b111, 2'b00, 1'b0, 16'h0}) begin
      nerr++; $display("FAIL reset_bus got %b%b%b %h %b %h want 111 0 0 0000", otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_address, otg_hpi_data_oe, otg_hpi_data_out); end
    nvec++; if ({otg_hpi_reset, busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 6'b010000) begin
      nerr++; $display("FAIL reset_ctl got %b want 010000", {otg_hpi_reset, busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid}); end
    nvec++; if ({rsp1_rdata, rsp0_rdata} !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h want 0", {rsp1_rdata, rsp0_rdata}); end
    model_reset();
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1;
    lows = 0; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (otg_hpi_reset === 1'b0) begin
        lows++;
        nvec++; if ({busy, req1_ready, req0_ready} !== 3'b100) begin nerr++; $display("FAIL chiprst_ctl got %b want 100", {busy, req1_ready, req0_ready}); end
        @(negedge clk_clk);
      end else done = 1;
    end
    nvec++; if (lows != RSTC) begin nerr++; $display("FAIL chiprst_len got %0d want %0d", lows, RSTC); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    use_fixed = 1; fixed_rd = 16'hBEEF;
    pend[0] = 1; pw[0] = 0; pa[0] = 2'd2; pd[0] = 16'($urandom);
    g_id.delete();
    repeat (12) cycle();
    use_fixed = 0;
    nvec++; if (g_id.size() != 1 || g_id[0] != 0) begin nerr++; $display("FAIL read_grant got %0d grants want 1 to client 0", g_id.size()); end
    nvec++; if (rsp0_rdata !== 16'hBEEF) begin nerr++; $display("FAIL read_data got %h want beef", rsp0_rdata); end
  endtask

  task automatic test_write();
    logic [15:0] prior;
    prior = exp_rd[1];
    pend[1] = 1; pw[1] = 1; pa[1] = 2'd1; pd[1] = 16'h1234;
    g_id.delete();
    repeat (12) cycle();
    nvec++; if (g_id.size() != 1 || g_id[0] != 1) begin nerr++; $display("FAIL write_grant got %0d grants want 1 to client 1", g_id.size()); end
    nvec++; if (rsp1_rdata !== prior) begin nerr++; $display("FAIL write_rdata got %h want %h", rsp1_rdata, prior); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      for (int w = 0; w < 2; w++) if (!pend[w] && $urandom_range(0, 3) == 0) new_req(w);
      cycle();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 34; i++) begin
      for (int w = 0; w < 2; w++) if (!pend[w]) new_req(w);
      cycle();
    end
    nvec++; if (g_id.size() < 4) begin nerr++; $display("FAIL rr_count got %0d want >=4", g_id.size()); end
    for (int j = 0; j < 4 && j < g_id.size(); j++) begin
      nvec++; if (g_id[j] != (j % 2)) begin nerr++; $display("FAIL rr_order[%0d] got %0d want %0d", j, g_id[j], j % 2); end
      if (j > 0) begin
        nvec++; if (g_cyc[j] - g_cyc[j-1] != LAT + 1) begin nerr++; $display("FAIL rr_spacing[%0d] got %0d want %0d", j, g_cyc[j] - g_cyc[j-1], LAT + 1); end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    new_req(0); pw[0] = 0;
    for (int i = 0; i < 20 && !(act && k == S + 2); i++) cycle();
    nvec++; if (!(act && k == S + 2)) begin nerr++; $display("FAIL mid_reach got k=%0d want %0d", k, S + 2); end
    #2; reset_reset_n = 0; #1;
    nvec++; if ({otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset, busy} !== 5'b11101) begin
      nerr++; $display("FAIL mid_async got %b want 11101", {otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset, busy}); end
    model_reset();
    repeat (6) begin
      @(negedge clk_clk);
      nvec++; if ({rsp1_valid, rsp0_valid, otg_hpi_cs} !== 3'b001) begin nerr++; $display("FAIL mid_norsp got %b want 001", {rsp1_valid, rsp0_valid, otg_hpi_cs}); end
    end
    test_reset();
  endtask

  initial begin
    model_reset();
    use_fixed = 0; fixed_rd = '0;
    test_reset();
    test_read();
    test_random();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
